// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared CPU memory-side types, segment prefixes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_MISS_REQ  = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_RESP      = 3'd4
    } cache_state_t;

    localparam logic [2:0] KSEG0_PREFIX = 3'b100;
    localparam logic [2:0] KSEG1_PREFIX = 3'b101;

    // kseg0/kseg1 both map onto the low 512 MiB of physical space.
    function automatic logic [31:0] virt_to_phys(input logic [31:0] vaddr);
        return vaddr & 32'h1FFF_FFFF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module      : icache_array
// Description : Flop-based tag/data/valid storage, one read and one write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_array #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_all,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag_mem  [LINES];
    logic [31:0]      r_data_mem [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (flush_all) begin
                r_valid <= '0;
            end
            if (wr_en) begin
                r_valid[wr_index] <= 1'b1;
            end
        end
    end

    // Payload arrays carry no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag_mem[wr_index]  <= wr_tag;
            r_data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag_mem[rd_index];
    assign rd_data  = r_data_mem[rd_index];

endmodule

`default_nettype wire

// File: rtl/inst_cache_resp.sv
// ============================================================================
// Module      : inst_cache_resp
// Description : Direct-mapped instruction cache responder with SRAM-like miss bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_cache_resp
    import cpu_mem_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cache_call_begin,
    input  logic [ADDR_W-1:0] cache_call_addr,
    input  logic              cache_flush,
    output logic              cache_return_ready,
    output logic [31:0]       cache_return_instruction,
    output logic              cache_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    cache_state_t        r_state;
    logic [ADDR_W-1:0]   r_phys;
    logic                r_cacheable;
    logic                r_flush_pending;
    logic                r_mem_req;
    logic [31:0]         r_resp_data;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_rd_valid;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [31:0]         w_rd_data;
    logic                w_hit;
    logic                w_data_done;
    logic                w_fill;
    logic                w_flush_all;

    assign w_index = r_phys[INDEX_W+1:2];
    assign w_tag   = r_phys[ADDR_W-1:INDEX_W+2];

    assign w_hit       = r_cacheable && w_rd_valid && (w_rd_tag == w_tag);
    assign w_data_done = mem_data_ok &&
                         ((r_state == ST_MISS_WAIT) ||
                          ((r_state == ST_MISS_REQ) && mem_addr_ok));
    assign w_fill      = w_data_done && r_cacheable;
    // A new call wins over a flush; the flush waits for an IDLE cycle with no call.
    assign w_flush_all = (r_state == ST_IDLE) && !cache_call_begin &&
                         (cache_flush || r_flush_pending);

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .flush_all (w_flush_all),
        .rd_index  (w_index),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_data   (w_rd_data),
        .wr_en     (w_fill),
        .wr_index  (w_index),
        .wr_tag    (w_tag),
        .wr_data   (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_phys          <= '0;
            r_cacheable     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_mem_req       <= 1'b0;
            r_resp_data     <= '0;
        end else begin
            if (w_flush_all) begin
                r_flush_pending <= 1'b0;
            end else if (cache_flush) begin
                r_flush_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cache_call_begin) begin
                        r_phys      <= virt_to_phys(cache_call_addr);
                        r_cacheable <= (cache_call_addr[ADDR_W-1:ADDR_W-3] == KSEG0_PREFIX);
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_resp_data <= w_rd_data;
                        r_state     <= ST_RESP;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_state   <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        if (mem_data_ok) begin
                            r_resp_data <= mem_rdata;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_MISS_WAIT;
                        end
                    end
                end
                ST_MISS_WAIT: begin
                    if (mem_data_ok) begin
                        r_resp_data <= mem_rdata;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cache_return_ready       = (r_state == ST_RESP);
    assign cache_return_instruction = (r_state == ST_RESP) ? r_resp_data : 32'd0;
    assign cache_busy               = (r_state != ST_IDLE) || cache_call_begin;
    assign mem_req                  = r_mem_req;
    assign mem_addr                 = r_phys;

endmodule

`default_nettype wire

// File: tb/tb_inst_cache_resp.sv
// ============================================================================
// Module      : tb_inst_cache_resp
// Description : Directed self-checking bench for inst_cache_resp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_cache_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache_call_begin;
    logic [31:0] cache_call_addr;
    logic        cache_flush;
    logic        cache_return_ready;
    logic [31:0] cache_return_instruction;
    logic        cache_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad = 0;
    int zero_err = 0;
    int busy_err = 0;
    int proto_err = 0;
    logic outstanding;

    logic        f_req_seen;
    logic [31:0] f_req_addr;
    logic        f_req_stable;
    int          f_req_cycles;
    int          f_lat;
    int          f_dok;
    logic [31:0] f_word;

    inst_cache_resp dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache_call_begin         (cache_call_begin),
        .cache_call_addr          (cache_call_addr),
        .cache_flush              (cache_flush),
        .cache_return_ready       (cache_return_ready),
        .cache_return_instruction (cache_return_instruction),
        .cache_busy               (cache_busy),
        .mem_req                  (mem_req),
        .mem_addr                 (mem_addr),
        .mem_addr_ok              (mem_addr_ok),
        .mem_data_ok              (mem_data_ok),
        .mem_rdata                (mem_rdata)
    );

    always #5 clk = ~clk;

    // A new call must never arrive while a previous one is still outstanding.
    always @(posedge clk) begin
        if (reset) begin
            outstanding <= 1'b0;
        end else begin
            if (cache_call_begin && outstanding) proto_err <= proto_err + 1;
            if (cache_call_begin) outstanding <= 1'b1;
            else if (cache_return_ready) outstanding <= 1'b0;
        end
    end

    // Issue one fetch and act as the memory; records what was observed.
    task automatic fetch(input logic [31:0] addr, input int aok_delay, input int data_delay,
                         input logic same, input logic flush_wait, input logic [31:0] rdata);
        bit accepted;
        bit given;
        int waitc;
        f_req_seen = 0; f_req_addr = 0; f_req_stable = 1; f_req_cycles = 0;
        f_lat = -1; f_dok = -1; f_word = 0;
        accepted = 0; given = 0; waitc = 0;
        @(posedge clk); #1;
        cache_call_begin = 1; cache_call_addr = addr;
        @(posedge clk); #1;
        cache_call_begin = 0; cache_call_addr = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0; cache_flush = 0;
            if (cache_return_ready) begin
                f_lat = c; f_word = cache_return_instruction;
                break;
            end
            if (cache_return_instruction !== 32'd0) zero_err++;
            if (cache_busy !== 1'b1) busy_err++;
            if (!accepted) begin
                if (mem_req) begin
                    if (!f_req_seen) begin
                        f_req_seen = 1; f_req_addr = mem_addr;
                    end else if (mem_addr !== f_req_addr) begin
                        f_req_stable = 0;
                    end
                    if (f_req_cycles == aok_delay) begin
                        mem_addr_ok = 1; accepted = 1;
                        if (same) begin
                            mem_data_ok = 1; mem_rdata = rdata; given = 1; f_dok = c;
                        end
                    end
                    f_req_cycles++;
                end
            end else if (!given) begin
                if (mem_req) f_req_stable = 0;
                if (flush_wait) cache_flush = 1;
                if (waitc == data_delay) begin
                    mem_data_ok = 1; mem_rdata = rdata; given = 1; f_dok = c;
                end
                waitc++;
            end
        end
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0; cache_flush = 0;
    endtask

    task automatic test_reset();
        reset = 1; cache_call_begin = 0; cache_call_addr = 0; cache_flush = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        total++; if (cache_return_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cache_return_ready); end
        total++; if (cache_return_instruction !== 32'd0) begin bad++; $display("FAIL reset_insn got=%h want=0", cache_return_instruction); end
        total++; if (cache_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", cache_busy); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_req); end
        total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    endtask

    task automatic test_boot_uncached();
        fetch(32'hbfc00000, 0, 1, 0, 0, 32'h3c080001);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL boot_req got=%b want=1", f_req_seen); end
        total++; if (f_req_addr !== 32'h1fc00000) begin bad++; $display("FAIL boot_addr got=%h want=1fc00000", f_req_addr); end
        total++; if (f_lat !== 5) begin bad++; $display("FAIL boot_latency got=%0d want=5", f_lat); end
        total++; if (f_word !== 32'h3c080001) begin bad++; $display("FAIL boot_word got=%h want=3c080001", f_word); end
        fetch(32'hbfc00000, 0, 0, 0, 0, 32'h3c080002);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL boot_repeat_miss got=%b want=1", f_req_seen); end
        total++; if (f_word !== 32'h3c080002) begin bad++; $display("FAIL boot_repeat_word got=%h want=3c080002", f_word); end
    endtask

    task automatic test_cached_miss_hit();
        fetch(32'h80001000, 0, 0, 0, 0, 32'h24090005);
        total++; if (f_req_addr !== 32'h00001000) begin bad++; $display("FAIL miss_addr got=%h want=00001000", f_req_addr); end
        total++; if (f_lat !== 4) begin bad++; $display("FAIL miss_latency got=%0d want=4", f_lat); end
        total++; if (f_word !== 32'h24090005) begin bad++; $display("FAIL miss_word got=%h want=24090005", f_word); end
        fetch(32'h80001000, 0, 0, 0, 0, 32'hdeadbeef);
        total++; if (f_req_seen !== 1'b0) begin bad++; $display("FAIL hit_no_req got=%b want=0", f_req_seen); end
        total++; if (f_lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", f_lat); end
        total++; if (f_word !== 32'h24090005) begin bad++; $display("FAIL hit_word got=%h want=24090005", f_word); end
        @(negedge clk);
        total++; if (cache_return_ready !== 1'b0 || cache_return_instruction !== 32'd0) begin
            bad++; $display("FAIL ready_pulse got=%b/%h want=0/0", cache_return_ready, cache_return_instruction);
        end
    endtask

    task automatic test_conflict();
        fetch(32'h80002000, 0, 0, 0, 0, 32'h11111111);
        total++; if (f_req_addr !== 32'h00002000 || f_req_seen !== 1'b1) begin bad++; $display("FAIL conflict_b_miss got=%b/%h want=1/00002000", f_req_seen, f_req_addr); end
        fetch(32'h80001000, 0, 0, 0, 0, 32'h22222222);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL conflict_a_evicted got=%b want=1", f_req_seen); end
        total++; if (f_word !== 32'h22222222) begin bad++; $display("FAIL conflict_a_word got=%h want=22222222", f_word); end
        fetch(32'h80002000, 0, 0, 0, 0, 32'h33333333);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL conflict_b_evicted got=%b want=1", f_req_seen); end
    endtask

    task automatic test_flush();
        fetch(32'h80000040, 0, 0, 0, 0, 32'h44444444);
        fetch(32'h80000040, 0, 0, 0, 0, 32'h0);
        total++; if (f_req_seen !== 1'b0 || f_word !== 32'h44444444) begin bad++; $display("FAIL flush_prefill got=%b/%h want=0/44444444", f_req_seen, f_word); end
        @(posedge clk); #1 cache_flush = 1;
        @(posedge clk); #1 cache_flush = 0;
        fetch(32'h80000040, 0, 0, 0, 0, 32'h55555555);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL flush_idle_miss got=%b want=1", f_req_seen); end
        total++; if (f_word !== 32'h55555555) begin bad++; $display("FAIL flush_idle_word got=%h want=55555555", f_word); end
        fetch(32'h80000080, 0, 2, 0, 1, 32'h66666666);
        total++; if (f_word !== 32'h66666666) begin bad++; $display("FAIL flush_wait_word got=%h want=66666666", f_word); end
        @(posedge clk);
        fetch(32'h80000080, 0, 0, 0, 0, 32'h77777777);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL flush_wait_miss got=%b want=1", f_req_seen); end
    endtask

    task automatic test_handshake();
        fetch(32'h80000100, 3, 0, 0, 0, 32'h88888888);
        total++; if (f_req_stable !== 1'b1) begin bad++; $display("FAIL hs_stable got=%b want=1", f_req_stable); end
        total++; if (f_req_cycles !== 4) begin bad++; $display("FAIL hs_req_cycles got=%0d want=4", f_req_cycles); end
        total++; if (f_req_addr !== 32'h00000100) begin bad++; $display("FAIL hs_addr got=%h want=00000100", f_req_addr); end
        total++; if (f_lat !== 7) begin bad++; $display("FAIL hs_latency got=%0d want=7", f_lat); end
        fetch(32'h80000200, 1, 0, 1, 0, 32'h99999999);
        total++; if (f_lat !== 4) begin bad++; $display("FAIL same_cycle_latency got=%0d want=4", f_lat); end
        total++; if (f_word !== 32'h99999999) begin bad++; $display("FAIL same_cycle_word got=%h want=99999999", f_word); end
        fetch(32'h80000200, 0, 0, 0, 0, 32'h0);
        total++; if (f_req_seen !== 1'b0 || f_word !== 32'h99999999) begin bad++; $display("FAIL same_cycle_fill got=%b/%h want=0/99999999", f_req_seen, f_word); end
    endtask

    task automatic test_reset_mid_miss();
        int readies;
        fetch(32'h80000300, 0, 0, 0, 0, 32'haaaaaaaa);
        fetch(32'h80000300, 0, 0, 0, 0, 32'h0);
        total++; if (f_req_seen !== 1'b0) begin bad++; $display("FAIL rmm_prefill_hit got=%b want=0", f_req_seen); end
        @(posedge clk); #1 cache_call_begin = 1; cache_call_addr = 32'h80000400;
        @(posedge clk); #1 cache_call_begin = 0; cache_call_addr = 0;
        @(posedge clk); #1;
        @(negedge clk); mem_addr_ok = 1;
        @(posedge clk); #1 mem_addr_ok = 0; reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmm_req got=%b want=0", mem_req); end
        total++; if (cache_busy !== 1'b0) begin bad++; $display("FAIL rmm_busy got=%b want=0", cache_busy); end
        readies = 0;
        mem_data_ok = 1; mem_rdata = 32'hbbbbbbbb;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_data_ok = 0; mem_rdata = 0;
            if (cache_return_ready) readies++;
        end
        total++; if (readies !== 0) begin bad++; $display("FAIL rmm_no_ready got=%0d want=0", readies); end
        fetch(32'h80000300, 0, 0, 0, 0, 32'hcccccccc);
        total++; if (f_req_seen !== 1'b1) begin bad++; $display("FAIL rmm_valid_cleared got=%b want=1", f_req_seen); end
    endtask

    task automatic test_idle_outputs();
        total++; if (zero_err !== 0) begin bad++; $display("FAIL insn_zero_when_idle got=%0d want=0", zero_err); end
        total++; if (busy_err !== 0) begin bad++; $display("FAIL busy_during_fetch got=%0d want=0", busy_err); end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL call_while_busy got=%0d want=0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_boot_uncached();
        test_cached_miss_hit();
        test_conflict();
        test_flush();
        test_handshake();
        test_reset_mid_miss();
        test_idle_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
